// File: rtl/multiplexer_mac.sv
// Board-level sum-of-products engine: buffers N operand pairs from the switches, accumulates
// sum(A_i*B_i) one pair per cycle and shows operands or result on four seven-segment digits.
module multiplexer_mac #(
  parameter int unsigned W        = 8,
  parameter int unsigned N        = 2,
  parameter int unsigned DEBOUNCE = 250000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [9:0] LEDR
);

  localparam int unsigned RW = 2 * W + $clog2(N);
  localparam int unsigned BN = 2 * N;
  localparam int unsigned PW = $clog2(BN);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  logic clk;
  logic rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];

  // Index 0 is the load button (KEY[1]), index 1 the start button (KEY[2]).
  logic [1:0]    btn_raw;
  logic [1:0]    s1_q, s2_q, db_q, db_prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    pulse;
  logic          v1_q, v2_q;

  assign btn_raw = KEY[2:1];
  assign pulse   = db_prev_q & ~db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      db_q      <= 2'b11;
      db_prev_q <= 2'b11;
      v1_q      <= 1'b1;
      v2_q      <= 1'b1;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      db_prev_q <= db_q;
      v1_q      <= KEY[3];
      v2_q      <= v1_q;
      for (int k = 0; k < 2; k++) begin
        if (s2_q[k] == db_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CW'(DEBOUNCE - 1)) begin
          db_q[k]  <= s2_q[k];
          cnt_q[k] <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  logic          load_pulse, start_pulse;
  state_e        state_q;
  logic [W-1:0]  opbuf_q [BN];
  logic [PW-1:0] wr_ptr_q;
  logic [IW-1:0] i_q;
  logic [RW-1:0] acc_q, result_q;
  logic          done_q;
  logic [W-1:0]  mac_a, mac_b;
  logic [RW-1:0] prod;

  assign load_pulse  = pulse[0];
  assign start_pulse = pulse[1];

  always_comb begin
    mac_a = opbuf_q[PW'({i_q, 1'b0})];
    mac_b = opbuf_q[PW'({i_q, 1'b1})];
    prod  = RW'(mac_a) * RW'(mac_b);
  end

  // Start is checked first so a coincident load pulse is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      i_q      <= '0;
      for (int k = 0; k < int'(BN); k++) opbuf_q[k] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            state_q <= StMac;
            acc_q   <= '0;
            i_q     <= '0;
          end else if (load_pulse && SW[9]) begin
            opbuf_q[wr_ptr_q] <= SW[W-1:0];
            wr_ptr_q <= (wr_ptr_q == PW'(BN - 1)) ? '0 : wr_ptr_q + 1'b1;
            done_q   <= 1'b0;
          end
        end
        StMac: begin
          acc_q <= acc_q + prod;
          i_q   <= i_q + 1'b1;
          if (i_q == IW'(N - 1)) state_q <= StDone;
        end
        StDone: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [PW-1:0] last_ptr, a_idx, b_idx;
  logic [31:0]   res_ext;
  logic [15:0]   disp;
  logic          overflow, busy;

  always_comb begin
    last_ptr = (wr_ptr_q == '0) ? PW'(BN - 1) : wr_ptr_q - 1'b1;
    a_idx    = last_ptr & ~PW'(1);
    b_idx    = a_idx | PW'(1);
    res_ext  = 32'(result_q);
    overflow = |res_ext[31:16];
    busy     = (state_q != StIdle);
    disp     = v2_q ? {8'(opbuf_q[a_idx]), 8'(opbuf_q[b_idx])} : res_ext[15:0];
    HEX3     = seg7(disp[15:12]);
    HEX2     = seg7(disp[11:8]);
    HEX1     = seg7(disp[7:4]);
    HEX0     = seg7(disp[3:0]);
    LEDR     = {overflow, busy, done_q, 4'b0000, 3'(wr_ptr_q)};
  end

  logic unused_sw;
  assign unused_sw = ^SW[8:W];

endmodule
